// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment driver command port between
// NUM_REQ clients, with a clear on every hand-over and bounded-hold pre-emption.
//
// state   | meaning
// IDLE    | display blanked, picking the next owner from req
// CLEAR   | one-cycle seg_clear before the new owner takes the port
// OWN     | winner's commands routed straight through to the driver
// RELEASE | one-cycle blanked gap after the owner lets go or is pre-empted
module seg_display_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int HOLD_MAX = 256,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic [4*NUM_REQ-1:0]   in_data,
  input  logic [NUM_REQ-1:0]     in_shift,
  input  logic [NUM_REQ-1:0]     in_write,
  input  logic [NUM_REQ-1:0]     in_clear,
  input  logic [NUM_REQ-1:0]     in_off,
  output logic [3:0]             seg_data,
  output logic                   seg_shift,
  output logic                   seg_write,
  output logic                   seg_clear,
  output logic                   seg_off,
  output logic                   preempt
);

  localparam int                 IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   HOLD_SAT   = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0]   HOLD_LIM   = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;
  localparam bit                 PREEMPT_EN = (HOLD_MAX != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner;
  logic [CNT_W-1:0]   hold_cnt;

  logic [IDX_W-1:0]   rr_pick;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic [NUM_REQ-1:0] win_mask;
  logic               others_wait;
  logic               owner_req;
  logic               hold_hit;
  logic               force_rel;

  // First requester after ptr, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    rr_pick = '0;
    found   = 1'b0;
    cand    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

  assign win_mask    = NUM_REQ'(1) << winner;
  assign others_wait = |(req & ~win_mask);
  assign owner_req   = req[winner];
  assign hold_hit    = PREEMPT_EN && (hold_cnt >= HOLD_LIM);
  assign force_rel   = hold_hit && others_wait;

  // A voluntary drop on the expiry cycle counts as a normal release.
  assign preempt = (state == OWN) && owner_req && force_rel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      winner   <= '0;
      ptr      <= LAST_IDX;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            winner <= rr_pick;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          gnt      <= win_mask;
          hold_cnt <= '0;
          state    <= OWN;
        end
        OWN: begin
          if (!owner_req || force_rel) begin
            gnt   <= '0;
            ptr   <= winner;
            state <= RELEASE;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    seg_data  = '0;
    seg_shift = 1'b0;
    seg_write = 1'b0;
    seg_clear = 1'b0;
    seg_off   = 1'b1;
    case (state)
      CLEAR: seg_clear = 1'b1;
      OWN: begin
        seg_data  = in_data[{winner, 2'b00} +: 4];
        seg_shift = in_shift[winner];
        seg_write = in_write[winner];
        seg_clear = in_clear[winner];
        seg_off   = in_off[winner];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized scoreboard bench for seg_display_arbiter: a per-cycle ownership
// model pushes expected driver outputs, a negedge monitor pops and compares.
module tb_seg_display_arbiter;
  localparam int N    = 2;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req, gnt, in_shift, in_write, in_clear, in_off;
  logic [4*N-1:0] in_data;
  logic [3:0]     seg_data;
  logic           seg_shift, seg_write, seg_clear, seg_off, preempt;

  seg_display_arbiter #(.NUM_REQ(N), .HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .in_data(in_data), .in_shift(in_shift), .in_write(in_write),
    .in_clear(in_clear), .in_off(in_off),
    .seg_data(seg_data), .seg_shift(seg_shift), .seg_write(seg_write),
    .seg_clear(seg_clear), .seg_off(seg_off), .preempt(preempt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int model_preempts = 0;
  int dut_preempts = 0;
  logic [10:0] exp_q[$];

  // Reference model: who owns the port, who is about to, and for how long.
  int m_owner, m_cand, m_ptr, m_owned;
  bit m_rel;

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    return ((int'(v) >> i) & 1) == 1;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_cand = -1; m_rel = 1'b0; m_ptr = N - 1; m_owned = 0;
  endfunction

  function automatic bit others_waiting(input int who);
    for (int j = 0; j < N; j++)
      if (j != who && bitof(req, j)) return 1'b1;
    return 1'b0;
  endfunction

  // m_owned counts completed owned cycles; the current one is m_owned+1.
  function automatic bit hold_expired();
    return (HOLD != 0) && (m_owned + 1 >= HOLD);
  endfunction

  function automatic void model_advance();
    if (m_owner >= 0) begin
      if (!bitof(req, m_owner) || (hold_expired() && others_waiting(m_owner))) begin
        m_ptr = m_owner; m_owner = -1; m_rel = 1'b1;
      end else m_owned++;
    end else if (m_cand >= 0) begin
      m_owner = m_cand; m_cand = -1; m_owned = 0;
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (req != '0) begin
      for (int k = 1; k <= N; k++)
        if (bitof(req, (m_ptr + k) % N)) begin m_cand = (m_ptr + k) % N; break; end
    end
  endfunction

  function automatic logic [10:0] expected();
    logic [1:0] g; logic [3:0] d; logic p;
    if (m_owner >= 0) begin
      g = 2'(1 << m_owner);
      d = 4'((int'(in_data) >> (4 * m_owner)) & 15);
      p = bitof(req, m_owner) && hold_expired() && others_waiting(m_owner);
      if (p) model_preempts++;
      return {g, d, bitof(in_shift, m_owner), bitof(in_write, m_owner),
              bitof(in_clear, m_owner), bitof(in_off, m_owner), p};
    end
    return {2'b00, 4'h0, 1'b0, 1'b0, (m_cand >= 0), 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle %0d act=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rst_v);
    @(posedge clk);
    cyc++;
    if (rst) model_advance(); else model_reset();
    #1;
    rst      = rst_v;
    req      = r;
    in_data  = 8'($urandom);
    in_shift = 2'($urandom);
    in_write = 2'($urandom);
    in_clear = 2'($urandom);
    in_off   = 2'($urandom);
    if (!rst_v) model_reset();
    exp_q.push_back(expected());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, int'(gnt), 0);
    check({tag, "_seg_data"}, int'(seg_data), 0);
    check({tag, "_strobes"}, int'({seg_shift, seg_write, seg_clear}), 0);
    check({tag, "_seg_off"}, int'(seg_off), 1);
    check({tag, "_preempt"}, int'(preempt), 0);
  endtask

  // Reset asserted between edges while a requester owns the port.
  task automatic async_reset_mid();
    #2;
    exp_q.delete();
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_rst");
  endtask

  initial begin : monitor
    logic [10:0] e, act;
    forever begin
      @(negedge clk);
      if (preempt === 1'b1) dut_preempts++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {gnt, seg_data, seg_shift, seg_write, seg_clear, seg_off, preempt};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL outputs cycle %0d act gnt/data/sh/wr/clr/off/pre=%b exp=%b", cyc, act, e);
        end
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] r;
    rst = 1'b0; req = '0; in_data = '0;
    in_shift = '0; in_write = '0; in_clear = '0; in_off = '0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    repeat (3) step(2'b00, 1'b0);
    step(2'b00, 1'b1);

    // single requester, foreign strobes ignored
    repeat (3) step(2'b00, 1'b1);
    repeat (12) step(2'b01, 1'b1);
    repeat (4) step(2'b00, 1'b1);

    // simultaneous requests, hand-over, round-robin return
    repeat (6) step(2'b11, 1'b1);
    repeat (8) step(2'b10, 1'b1);
    repeat (2) step(2'b00, 1'b1);
    repeat (10) step(2'b11, 1'b1);
    repeat (5) step(2'b00, 1'b1);

    // waiter arrives early: pre-emption at hold expiry, then alternation
    repeat (4) step(2'b01, 1'b1);
    repeat (30) step(2'b11, 1'b1);
    repeat (5) step(2'b00, 1'b1);

    // lone owner saturates, late waiter forces release
    repeat (50) step(2'b01, 1'b1);
    repeat (6) step(2'b11, 1'b1);
    repeat (5) step(2'b00, 1'b1);

    // owner drops req exactly on the expiry cycle
    for (int i = 0; i < 10 && m_owner != 0; i++) step(2'b01, 1'b1);
    repeat (6) step(2'b11, 1'b1);
    step(2'b10, 1'b1);
    repeat (8) step(2'b10, 1'b1);
    repeat (4) step(2'b00, 1'b1);

    // async reset while requester 1 owns; requester 0 wins afterwards
    for (int i = 0; i < 10 && m_owner != 1; i++) step(2'b10, 1'b1);
    repeat (3) step(2'b10, 1'b1);
    async_reset_mid();
    step(2'b11, 1'b0);
    step(2'b11, 1'b1);
    repeat (8) step(2'b11, 1'b1);
    repeat (4) step(2'b00, 1'b1);

    // random request traffic
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) r = r ^ 2'(1 << $urandom_range(0, 1));
      step(r, 1'b1);
    end
    repeat (5) step(2'b00, 1'b1);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("queue_drain", exp_q.size(), 0);
    check("preempt_count", dut_preempts, model_preempts);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares one seven-segment display driver command interface (seg_data/shift/write/clear/off) between NUM_REQ requesters, e.g. the scrolling controller and a CAN status writer.
- Grants are round-robin with a request/grant handshake.
- A one-cycle clear is issued on every hand-over, and a bounded hold time lets a waiting requester pre-empt the current owner.
- Sits between the display clients and the segment shift-register driver.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
HOLD_MAX, 256, max owned cycles before pre-emption when another requester waits; 0 disables pre-emption
CNT_W, 16, hold counter width; must hold HOLD_MAX

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
req  input  NUM_REQ  level request per requester; held high while ownership is wanted
gnt  output  NUM_REQ  one-hot grant, registered
in_data  input  4*NUM_REQ  per-requester seg_data, requester i at bits [4i+3:4i]
in_shift  input  NUM_REQ  per-requester shift strobe
in_write  input  NUM_REQ  per-requester write strobe
in_clear  input  NUM_REQ  per-requester clear strobe
in_off  input  NUM_REQ  per-requester display-off level
seg_data  output  4  to display driver
seg_shift  output  1  to display driver
seg_write  output  1  to display driver
seg_clear  output  1  to display driver
seg_off  output  1  to display driver
preempt  output  1  one-cycle pulse when an owner is forcibly released

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - gnt=0, seg_data=0, seg_shift=0, seg_write=0, seg_clear=0, seg_off=1 (blanked), preempt=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first. Hold counter = 0.
- Release takes effect on the first clk edge after rst=1.
- States: IDLE, CLEAR, OWN, RELEASE.
- IDLE:
  - Outputs are idle: strobes 0, seg_data=0, seg_off=1.
  - If any req is high, the winner is the first requester with req high searching ptr+1, ptr+2, ... modulo NUM_REQ. The winner is latched and the state moves to CLEAR.
- CLEAR:
  - seg_clear=1 for exactly one cycle, gnt still 0, seg_off=1.
  - Next state is OWN unconditionally. gnt[winner]=1 from the OWN cycle onward, and the hold counter is cleared.
  - req→gnt latency: req seen high at edge t in IDLE gives gnt at edge t+2.
  - If the winner drops req during CLEAR, OWN is still entered, then released next cycle.
- OWN:
  - Outputs are a combinational mux of the winner's in_data, in_shift, in_write, in_clear and in_off.
  - Non-granted inputs are ignored entirely.
  - The hold counter increments each OWN cycle and saturates at HOLD_MAX.
- Leaving OWN for RELEASE:
  - When req[winner]=0, go to RELEASE.
  - When HOLD_MAX≠0, counter==HOLD_MAX-1 and any other req is high, go to RELEASE and assert preempt for that same cycle.
  - If no other requester waits, ownership continues indefinitely with the counter saturated.
  - A waiter arriving after saturation causes pre-emption on the next cycle.
  - If req drop and pre-emption occur in the same cycle, treat it as a normal release: preempt=0.
- RELEASE:
  - gnt=0, idle outputs (seg_off=1), for one cycle.
  - ptr ← winner, then go to IDLE.
  - Minimum gap between two grants is 3 cycles (RELEASE, IDLE, CLEAR).
- A pre-empted owner that keeps req high re-competes normally. With round-robin it is served after the others.
- gnt is never multi-hot and never changes except at state transitions.
- Widths: winner index is $clog2(NUM_REQ) bits. Pointer wrap is NUM_REQ-1 → 0.

Test Plan:
1. Reset, release rst, req=2'b01 at cycle 5 → seg_clear=1 at cycle 6, gnt=2'b01 at cycle 7. in_data[3:0]=9, in_write pulse → seg_data=9 and seg_write=1 in the same cycle. in_write[1] pulses are ignored.
2. req=2'b11 simultaneously from IDLE after reset → gnt=2'b01. Drop req[0] → RELEASE, IDLE, CLEAR, then gnt=2'b10. Re-raise both after req[1] drops → gnt=2'b01 (round-robin).
3. HOLD_MAX=8, req[0] owns, req[1] raised at OWN cycle 2 → preempt=1 on OWN cycle 8, gnt=0 next cycle, gnt=2'b10 three cycles later.
4. HOLD_MAX=8, req[0] sole requester for 50 cycles → no preempt, gnt stays 2'b01. Raise req[1] at cycle 50 → preempt next cycle.
5. Assert rst=0 mid-OWN between clock edges → gnt=0, seg_off=1, seg_clear=0 immediately. After release, requester 0 has priority.
6. req[0] drops on the exact pre-emption cycle with req[1] waiting → RELEASE with preempt=0, then req[1] granted.
